mistral_mul_arbiter: RTL



---
 rtl/mistral_dsp_pkg.sv | 18 +
 rtl/MISTRAL_MUL27X27.sv | 23 ++
 rtl/mistral_rr_arbiter.sv | 51 +++++
 rtl/mistral_mul_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mistral_dsp_pkg.sv
// Shared constants and helpers for the 27x27 DSP sharing logic.
package mistral_dsp_pkg;

  localparam int MUL27_W   = 27;
  localparam int MUL27_Y_W = 54;

  // Operand pair captured in the operand stage.
  typedef struct packed {
    logic [MUL27_W-1:0] a;
    logic [MUL27_W-1:0] b;
  } mul_op_t;

  // Requester-index width; a single requester still gets one bit.
  function automatic int idw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/MISTRAL_MUL27X27.sv
// Behavioural stand-in for the hard 27x27 multiplier atom: purely
// combinational, operands extended by their signedness, full 54-bit product.
module MISTRAL_MUL27X27
  import mistral_dsp_pkg::*;
#(
  parameter bit A_SIGNED = 1'b1,
  parameter bit B_SIGNED = 1'b1
) (
  input  logic [MUL27_W-1:0]   A,
  input  logic [MUL27_W-1:0]   B,
  output logic [MUL27_Y_W-1:0] Y
);

  logic [MUL27_Y_W-1:0] a_ext, b_ext;

  // Extend both operands to 54 bits; low 54 bits of the product are exact.
  always_comb begin
    a_ext = {{MUL27_W{A_SIGNED & A[MUL27_W-1]}}, A};
    b_ext = {{MUL27_W{B_SIGNED & B[MUL27_W-1]}}, B};
    Y     = a_ext * b_ext;
  end

endmodule

// File: rtl/mistral_rr_arbiter.sv
// Round-robin arbiter: searches from ptr, one-hot grant gated by en, and
// moves ptr to one past the winner whenever a grant is issued.
module mistral_rr_arbiter
  import mistral_dsp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = idw(N_REQ)
) (
  input  logic             CLK,
  input  logic             ACLR,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_idx,
  output logic             gnt_any
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW:0]   j;

  // Rotating-priority search: first requester at or after ptr wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = {1'b0, ptr_q} + (IDW+1)'(k);
      if (j >= (IDW+1)'(N_REQ)) j = j - (IDW+1)'(N_REQ);
      if (!gnt_any && req[j[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = j[IDW-1:0];
      end
    end
  end

  // One-hot grant and pointer advance, only when the pipeline can accept.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    if (en && gnt_any) begin
      gnt[gnt_idx] = 1'b1;
      ptr_d        = (gnt_idx == IDW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge CLK or negedge ACLR)
    if (!ACLR) ptr_q <= '0;
    else       ptr_q <= ptr_d;

endmodule

// File: rtl/mistral_mul_arbiter.sv
// Shares one 27x27 multiplier among N_REQ requesters: round-robin grant,
// operand stage S1, multiplier, result stage S2 driving the response bus.
// Build option MISTRAL_MULSHARE_PIPE_EN inserts S1b after the multiplier
// (latency 3 instead of 2, same throughput).
module mistral_mul_arbiter
  import mistral_dsp_pkg::*;
#(
  parameter int  N_REQ    = 4,
  parameter bit  A_SIGNED = 1'b1,
  parameter bit  B_SIGNED = 1'b1,
  localparam int IDW      = idw(N_REQ)
) (
  input  logic                     CLK,
  input  logic                     ACLR,
  input  logic [N_REQ-1:0]         REQ_VALID,
  output logic [N_REQ-1:0]         REQ_READY,
  input  logic [N_REQ*MUL27_W-1:0] REQ_A,
  input  logic [N_REQ*MUL27_W-1:0] REQ_B,
  output logic                     RSP_VALID,
  input  logic                     RSP_READY,
  output logic [IDW-1:0]           RSP_ID,
  output logic [MUL27_Y_W-1:0]     RSP_Y
);

  logic [N_REQ-1:0][MUL27_W-1:0] req_a, req_b;
  logic [IDW-1:0]       gnt_idx;
  logic                 gnt_any, arb_en, xfer;
  logic                 adv1, adv2;
  mul_op_t              op_q, op_d;
  logic [IDW-1:0]       id1_q, id1_d, id2_q, id2_d, s2_in_id;
  logic                 v1_q, v1_d, v2_q, v2_d, s2_in_v;
  logic [MUL27_Y_W-1:0] mul_y, y2_q, y2_d, s2_in_y;

  assign req_a = REQ_A;
  assign req_b = REQ_B;

  // A stage may advance when it is empty or its successor advances.
  assign adv2   = !v2_q || RSP_READY;
  assign arb_en = adv1 && ACLR;
  assign xfer   = gnt_any && arb_en;

  mistral_rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
    .CLK     (CLK),
    .ACLR    (ACLR),
    .req     (REQ_VALID),
    .en      (arb_en),
    .gnt     (REQ_READY),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  MISTRAL_MUL27X27 #(.A_SIGNED(A_SIGNED), .B_SIGNED(B_SIGNED)) u_mul (
    .A (op_q.a),
    .B (op_q.b),
    .Y (mul_y)
  );

`ifdef MISTRAL_MULSHARE_PIPE_EN
  logic                 advb;
  logic [MUL27_Y_W-1:0] yb_q, yb_d;
  logic [IDW-1:0]       idb_q, idb_d;
  logic                 vb_q, vb_d;

  assign advb     = !vb_q || adv2;
  assign adv1     = !v1_q || advb;
  assign s2_in_y  = yb_q;
  assign s2_in_id = idb_q;
  assign s2_in_v  = vb_q;

  // S1b captures the raw product so S2 never sees the multiplier path.
  always_comb begin
    yb_d  = yb_q;
    idb_d = idb_q;
    vb_d  = vb_q;
    if (advb) begin
      vb_d = v1_q;
      if (v1_q) begin
        yb_d  = mul_y;
        idb_d = id1_q;
      end
    end
  end

  // S1b register.
  always_ff @(posedge CLK or negedge ACLR)
    if (!ACLR) begin
      yb_q  <= '0;
      idb_q <= '0;
      vb_q  <= 1'b0;
    end else begin
      yb_q  <= yb_d;
      idb_q <= idb_d;
      vb_q  <= vb_d;
    end
`else
  assign adv1     = !v1_q || adv2;
  assign s2_in_y  = mul_y;
  assign s2_in_id = id1_q;
  assign s2_in_v  = v1_q;
`endif

  // S1 takes the granted requester's operands; data only moves on a transfer.
  always_comb begin
    op_d  = op_q;
    id1_d = id1_q;
    v1_d  = v1_q;
    if (adv1) begin
      v1_d = xfer;
      if (xfer) begin
        op_d.a = req_a[gnt_idx];
        op_d.b = req_b[gnt_idx];
        id1_d  = gnt_idx;
      end
    end
  end

  // S2 holds the response; frozen while the consumer stalls.
  always_comb begin
    y2_d  = y2_q;
    id2_d = id2_q;
    v2_d  = v2_q;
    if (adv2) begin
      v2_d = s2_in_v;
      if (s2_in_v) begin
        y2_d  = s2_in_y;
        id2_d = s2_in_id;
      end
    end
  end

  // S1/S2 registers; reset drops anything in flight.
  always_ff @(posedge CLK or negedge ACLR)
    if (!ACLR) begin
      op_q  <= '0;
      id1_q <= '0;
      v1_q  <= 1'b0;
      y2_q  <= '0;
      id2_q <= '0;
      v2_q  <= 1'b0;
    end else begin
      op_q  <= op_d;
      id1_q <= id1_d;
      v1_q  <= v1_d;
      y2_q  <= y2_d;
      id2_q <= id2_d;
      v2_q  <= v2_d;
    end

  assign RSP_VALID = v2_q;
  assign RSP_ID    = id2_q;
  assign RSP_Y     = y2_q;

endmodule
